// File: rtl/conv_sram_rd_arbiter.sv
// Round-robin read-port arbiter with burst locking between binary-convolution engines and the shared SRAM.
// Optional per-engine grant counters are built when ARB_STATS_EN is defined.
module conv_sram_rd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         sram_rd_addr,
  input  logic [DATA_W-1:0]         sram_rd_data
`ifdef ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ownIdx_q, ownIdx_d;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]   burstCnt_q, burstCnt_d;
  logic [ADDR_W-1:0]  sramAddr_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic               tagValid_q [RD_LAT+1];
  logic [IDX_W-1:0]   tagIdx_q   [RD_LAT+1];

  logic [IDX_W-1:0]   arbPtr;
  logic               winFound;
  logic [IDX_W-1:0]   winIdx;
  logic [NUM_REQ-1:0] ownMask;
  logic               othersReq;
  logic               capHit;
  logic               gntValid;
  logic [IDX_W-1:0]   gntIdx;
  logic [ADDR_W-1:0]  selAddr;

  function automatic logic [IDX_W-1:0] incWrap(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // A releasing owner hands the scan start to the engine after it; otherwise the round-robin pointer applies.
  always_comb begin
    arbPtr = (state_q == ST_OWNED) ? incWrap(ownIdx_q) : rrPtr_q;
  end

  always_comb begin
    logic [IDX_W-1:0] cand;
    winFound = 1'b0;
    winIdx   = '0;
    cand     = arbPtr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!winFound && req[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
      cand = incWrap(cand);
    end
  end

  always_comb begin
    ownMask           = '0;
    ownMask[ownIdx_q] = 1'b1;
    othersReq         = |(req & ~ownMask);
    capHit            = (burstCnt_q == CNT_W'(MAX_BURST));
  end

  always_comb begin
    logic doArb;
    state_d    = state_q;
    ownIdx_d   = ownIdx_q;
    rrPtr_d    = rrPtr_q;
    burstCnt_d = burstCnt_q;
    gntValid   = 1'b0;
    gntIdx     = '0;
    doArb      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        doArb = 1'b1;
      end
      ST_OWNED: begin
        if (!req[ownIdx_q] || (capHit && othersReq)) begin
          // Lock drop coinciding with the cap is folded into this single release.
          doArb      = 1'b1;
          state_d    = ST_IDLE;
          rrPtr_d    = incWrap(ownIdx_q);
          burstCnt_d = '0;
        end else begin
          gntValid = 1'b1;
          gntIdx   = ownIdx_q;
          if (!lock[ownIdx_q]) begin
            state_d    = ST_IDLE;
            rrPtr_d    = incWrap(ownIdx_q);
            burstCnt_d = '0;
          end else if (!capHit) begin
            burstCnt_d = burstCnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (doArb && winFound) begin
      gntValid = 1'b1;
      gntIdx   = winIdx;
      if (lock[winIdx]) begin
        state_d    = ST_OWNED;
        ownIdx_d   = winIdx;
        burstCnt_d = CNT_W'(1);
      end else begin
        rrPtr_d = incWrap(winIdx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gntValid && reset_b) begin
      gnt[gntIdx] = 1'b1;
    end
  end

  always_comb begin
    selAddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gntIdx == IDX_W'(i)) begin
        selAddr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      ownIdx_q   <= '0;
      rrPtr_q    <= '0;
      burstCnt_q <= '0;
      sramAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      ownIdx_q   <= ownIdx_d;
      rrPtr_q    <= rrPtr_d;
      burstCnt_q <= burstCnt_d;
      if (gntValid) begin
        sramAddr_q <= selAddr;
      end
    end
  end

  // Tag stage RD_LAT lines up with sram_rd_data; rvalid registers alongside rdata.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int s = 0; s <= RD_LAT; s++) begin
        tagValid_q[s] <= 1'b0;
        tagIdx_q[s]   <= '0;
      end
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      tagValid_q[0] <= gntValid;
      tagIdx_q[0]   <= gntIdx;
      for (int s = 1; s <= RD_LAT; s++) begin
        tagValid_q[s] <= tagValid_q[s-1];
        tagIdx_q[s]   <= tagIdx_q[s-1];
      end
      rvalid_q <= '0;
      if (tagValid_q[RD_LAT]) begin
        rvalid_q[tagIdx_q[RD_LAT]] <= 1'b1;
      end
      rdata_q <= sram_rd_data;
    end
  end

  assign sram_rd_addr = sramAddr_q;
  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;

`ifdef ARB_STATS_EN
  logic [15:0] grantCnt_q [NUM_REQ];

  // Clear wins over a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grantCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) begin
          grantCnt_q[i] <= '0;
        end else if (gnt[i] && (grantCnt_q[i] != 16'hFFFF)) begin
          grantCnt_q[i] <= grantCnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = grantCnt_q[i];
    end
  end
`endif

  gntOneHot: assert property (@(posedge clk) disable iff (!reset_b) $onehot0(gnt));
  gntNeedsReq: assert property (@(posedge clk) disable iff (!reset_b) (gnt & ~req) == '0);
  rvalidOneHot: assert property (@(posedge clk) disable iff (!reset_b) $onehot0(rvalid));

endmodule

// File: tb/tb_conv_sram_rd_arbiter.sv
// Scoreboard bench for conv_sram_rd_arbiter: a reference arbiter model predicts grants and
// queues expected read returns, popped and compared when they fall due.
module tb_conv_sram_rd_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 16;

  logic                      clk = 1'b0;
  logic                      reset_b = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        lock = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         sram_rd_addr;
  logic [DATA_W-1:0]         sram_rd_data;
`ifdef ARB_STATS_EN
  logic                      stats_clr = 1'b0;
  logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

  always #5 clk = ~clk;

  conv_sram_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .req(req),
    .lock(lock),
    .req_addr(req_addr),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data)
`ifdef ARB_STATS_EN
    ,
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  // SRAM macro model with RD_LAT cycles from address to data
  logic [DATA_W-1:0] sramPipe [RD_LAT];
  always @(posedge clk) begin
    sramPipe[0] <= memWord(sram_rd_addr);
    for (int k = 1; k < RD_LAT; k++) begin
      sramPipe[k] <= sramPipe[k-1];
    end
  end
  assign sram_rd_data = sramPipe[RD_LAT-1];

  typedef struct {
    int                due;
    int                idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sbQ[$];
  int                assertCount = 0;
  int                failCount = 0;
  int                cycleNum = 0;
  int                ownerM = -1;
  int                rrM = 0;
  int                cntM = 0;
  logic [ADDR_W-1:0] expAddrM = '0;
  logic [ADDR_W-1:0] addrCnt [NUM_REQ];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  function automatic int pickM(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference arbiter, one call per clock cycle
  task automatic modelStep(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l, output int g);
    int  o;
    bit  arb;
    int  ptr;
    g   = -1;
    arb = 1'b1;
    ptr = rrM;
    if (ownerM >= 0) begin
      o = ownerM;
      if (!r[o] || (cntM == MAX_BURST && (r & ~(1 << o)) != 0)) begin
        ownerM = -1;
        rrM    = (o + 1) % NUM_REQ;
        ptr    = rrM;
      end else begin
        arb = 1'b0;
        g   = o;
        if (!l[o]) begin
          ownerM = -1;
          rrM    = (o + 1) % NUM_REQ;
        end else if (cntM < MAX_BURST) begin
          cntM++;
        end
      end
    end
    if (arb) begin
      g = pickM(r, ptr);
      if (g >= 0) begin
        if (l[g]) begin
          ownerM = g;
          cntM   = 1;
        end else begin
          rrM = (g + 1) % NUM_REQ;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l);
    int          g;
    exp_t        e;
    logic [31:0] expG;
    @(negedge clk);
    req  = r;
    lock = l;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = addrCnt[i];
    end
    #1;
    checkOutput("sram_rd_addr", 32'(sram_rd_addr), 32'(expAddrM));
    if (sbQ.size() > 0 && sbQ[0].due == cycleNum) begin
      e = sbQ.pop_front();
      checkOutput("rvalid", 32'(rvalid), 32'(1 << e.idx));
      checkOutput("rdata", 32'(rdata), 32'(e.data));
    end else begin
      checkOutput("rvalid_idle", 32'(rvalid), 32'd0);
    end
    modelStep(r, l, g);
    expG = (g >= 0) ? 32'(1 << g) : 32'd0;
    checkOutput("gnt", 32'(gnt), expG);
    if (g >= 0) begin
      expAddrM = addrCnt[g];
      sbQ.push_back('{due: cycleNum + RD_LAT + 2, idx: g, data: memWord(addrCnt[g])});
      addrCnt[g] = addrCnt[g] + 1'b1;
    end
    cycleNum++;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_b = 1'b0;
    req     = '1;
    lock    = '0;
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'd0);
    checkOutput("rst_sram_rd_addr", 32'(sram_rd_addr), 32'd0);
    req = '0;
    @(posedge clk);
    #2;
    reset_b  = 1'b1;
    ownerM   = -1;
    rrM      = 0;
    cntM     = 0;
    expAddrM = '0;
    sbQ.delete();
    cycleNum++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus('0, '0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int e0Gnt;
    int e1Gnt;
    int firstGnt1;
    int doneCyc;
    addrCnt[0] = 12'h000;
    addrCnt[1] = 12'h100;
    doReset();

    // Single streaming engine, addresses 0..9
    for (int i = 0; i < 10; i++) applyStimulus(2'b01, 2'b00);
    idle(4);

    // Both engines unlocked: alternating grants and returns
    for (int i = 0; i < 10; i++) applyStimulus(2'b11, 2'b00);
    idle(4);

    // Engine 0 locked for 20 beats, engine 1 joins and is served at the cap
    e0Gnt = 0; e1Gnt = 0; firstGnt1 = -1; doneCyc = -1;
    for (int cyc = 0; cyc < 100 && e0Gnt < 20; cyc++) begin
      applyStimulus({(cyc >= 5 && e1Gnt == 0), 1'b1}, 2'b01);
      if (gnt[0]) e0Gnt++;
      if (gnt[1]) begin
        e1Gnt++;
        if (firstGnt1 < 0) firstGnt1 = cyc;
      end
      if (e0Gnt == 20) doneCyc = cyc;
    end
    checkOutput("cap_first_gnt1_cycle", 32'(firstGnt1), 32'd16);
    checkOutput("cap_e0_done_cycle", 32'(doneCyc), 32'd20);
    checkOutput("cap_e1_grants", 32'(e1Gnt), 32'd1);
    idle(4);

    // Lone locked engine keeps the port for 40 beats, then yields immediately
    e0Gnt = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'b01, 2'b01);
      if (gnt[0]) e0Gnt++;
    end
    checkOutput("lone_burst_grants", 32'(e0Gnt), 32'd40);
    applyStimulus(2'b11, 2'b01);
    checkOutput("saturated_cap_release", 32'(gnt), 32'h2);
    idle(4);

    // Random traffic with locks
    for (int i = 0; i < 300; i++) begin
      applyStimulus(NUM_REQ'($urandom_range(0, 3)), NUM_REQ'($urandom_range(0, 3)));
    end
    idle(4);

    // Reset with two reads in flight, pointer left at engine 1
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b01, 2'b00);
    doReset();
    idle(5);
    applyStimulus(2'b11, 2'b00);
    checkOutput("first_gnt_after_reset", 32'(gnt), 32'h1);
    idle(RD_LAT + 3);
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

`ifdef ARB_STATS_EN
    stats_clr = 1'b1;
    applyStimulus('0, '0);
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    for (int i = 0; i < 300; i++) applyStimulus(2'b10, 2'b00);
    applyStimulus('0, '0);
    checkOutput("stats_e1_count", 32'(grant_cnt[31:16]), 32'd300);
    checkOutput("stats_e0_count", 32'(grant_cnt[15:0]), 32'd0);
    stats_clr = 1'b1;
    applyStimulus('0, '0);
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    checkOutput("stats_clr_e1", 32'(grant_cnt[31:16]), 32'd0);
    checkOutput("stats_clr_e0", 32'(grant_cnt[15:0]), 32'd0);
    idle(RD_LAT + 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/conv_sram_rd_arbiter.md
Name: conv_sram_rd_arbiter

Overview:
Shares the single read port of the input/output SRAM between NUM_REQ binary-convolution engines, each of which streams row words from it.
- Arbitration is round-robin with burst locking, so an engine can hold the port while it fills its row pipeline; a burst-length cap bounds starvation.
- Each engine gets its read data back with a per-requester valid, at fixed latency.
- The block sits between the conv engines and the SRAM macro; it does not touch the write port or weight memory.

Parameters:
NUM_REQ, 2, number of requesting engines (2..4).
ADDR_W, 12, SRAM address width.
DATA_W, 16, SRAM data width.
RD_LAT, 1, SRAM read latency in cycles from sram_rd_addr change to sram_rd_data valid (1..3).
MAX_BURST, 16, max consecutive locked grants to one owner while another requester waits (2..64).

Ports:
clk  in  1  clock, all logic on posedge.
reset_b  in  1  reset, asynchronous, active-low.
req  in  NUM_REQ  per-engine read request, one address per cycle while high.
lock  in  NUM_REQ  per-engine burst hold; meaningful only while req of the same engine is high.
req_addr  in  NUM_REQ*ADDR_W  packed addresses; engine i uses bits [i*ADDR_W +: ADDR_W].
gnt  out  NUM_REQ  one-hot grant, combinational from registered state and req; address accepted this cycle.
rvalid  out  NUM_REQ  one-hot; rdata belongs to the flagged engine.
rdata  out  DATA_W  registered copy of sram_rd_data, broadcast to all engines.
sram_rd_addr  out  ADDR_W  registered SRAM read address.
sram_rd_data  in  DATA_W  SRAM read data.

Behaviour:
- Reset values:
  - Registers: sram_rd_addr=0, rdata=0, rvalid=0, owner=none, rr_ptr=0, burst_cnt=0, tag pipeline cleared.
  - Outputs: gnt=0 during reset.
  - Reset mid-operation discards all in-flight reads; no rvalid pulses after release until new grants.
- State: owner register with values NONE or index i.
- Transitions from NONE:
  - gnt goes to the first requesting index at or after rr_ptr, scanning upward with wrap.
  - If the winner's lock is high, owner := winner and burst_cnt := 1.
  - Otherwise owner stays NONE, and rr_ptr := winner+1 mod NUM_REQ.
- Transitions from owner i:
  - gnt[i]=req[i], and burst_cnt increments on each grant.
  - Release happens when any of the following occurs, then arbitration proceeds in the same cycle as from NONE with rr_ptr := i+1:
    - req[i]=0;
    - lock[i]=0, in which case that cycle's grant still goes to i, and owner := NONE next cycle;
    - burst_cnt==MAX_BURST while any other req is high.
  - burst_cnt saturates at MAX_BURST when no other requester waits, so the owner keeps the port.
- Simultaneous events: lock dropped on the same cycle the cap hits counts as a single release. A requester raising lock while not granted has no effect.
- Address path: on a grant to index g at cycle t:
  - sram_rd_addr <= req_addr[g] at t+1;
  - with no grant, sram_rd_addr holds its value.
- Read return:
  - A tag pipeline of depth RD_LAT+1 carries {valid, g}.
  - rdata <= sram_rd_data every cycle.
  - rvalid[g]=1 at cycle t+RD_LAT+2 for exactly one cycle.
  - Returns are strictly in grant order; one return per cycle max.
- At most one gnt bit is high per cycle. gnt never asserts for an engine with req low.
- Throughput: one grant per cycle sustained; no bubble on owner change.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16 packed) and input stats_clr (1 bit).
  - Each 16-bit counter increments on its gnt bit and saturates at 16'hFFFF.
  - stats_clr=1 zeroes all counters on the next edge, with clear taking priority over increment. Counters reset to 0.
- Undefined: these ports and counters do not exist; arbitration is unchanged.

Test Plan:
1. NUM_REQ=2, only req[0]=1, lock=0, addresses 0..9 one per cycle -> gnt[0] every cycle; sram_rd_addr follows one cycle later; with RD_LAT=1, rvalid[0] pulses 3 cycles after each grant, and rdata equals the model SRAM contents of addresses 0..9.
2. req=2'b11 continuously, lock=0 -> gnt alternates 01,10,01,...; rvalid alternates in the same order, delayed by RD_LAT+2.
3. req[0] with lock=1 for 20 beats, req[1] raised at beat 5, MAX_BURST=16 -> engine 0 is granted beats 1..16; engine 1 is granted the next cycle; engine 0 resumes after engine 1 drops req or lock.
4. Engine 0 locked alone for 40 beats, MAX_BURST=16 -> uninterrupted 40 grants; burst_cnt holds at 16.
5. Assert reset_b=0 for one cycle with two reads in flight -> no rvalid afterwards, and sram_rd_addr=0; the first grant after release goes to index 0.
6. ARB_STATS_EN: 300 grants to engine 1 -> grant_cnt[31:16]=300; stats_clr pulse -> both counters read 0 the next cycle; 70000 grants -> counter holds 16'hFFFF.
